// File: rtl/prism_in_cond.sv
// rtl/prism_in_cond.sv - per-channel glitch filter, edge detect, sticky flags and timestamped event FIFO
module prism_in_cond #(
    parameter int WIDTH  = 7,
    parameter int FILT_W = 4,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pin_in,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    output logic [WIDTH-1:0]  cond_out,
    output logic              irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 3;

    // configuration and status state
    logic [FILT_W-1:0] thresh;
    logic              filt_en;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  flags;
    logic              ovf;
    logic [WIDTH-1:0]  cond;
    logic [FILT_W-1:0] cnt [WIDTH];
    logic [TS_W-1:0]   ts;

    // FIFO pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [TS_W-1:0]   fifo_ts    [DEPTH];
    logic [CW-1:0]     fifo_chan  [DEPTH];
    logic              fifo_dir   [DEPTH];
    logic              fifo_multi [DEPTH];

    logic wr_ctrl, wr_edge, wr_flags, wr_fifo;
    logic unused_wdata;

    assign wr_ctrl  = cfg_wr && (cfg_addr == 2'd0);
    assign wr_edge  = cfg_wr && (cfg_addr == 2'd1);
    assign wr_flags = cfg_wr && (cfg_addr == 2'd2);
    assign wr_fifo  = cfg_wr && (cfg_addr == 2'd3);
    assign unused_wdata = ^cfg_wdata;

    logic [WIDTH-1:0]  cond_nxt;
    logic [FILT_W-1:0] cnt_nxt [WIDTH];

    // glitch filter: a changed pin must persist thresh+1 samples before cond follows
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cond_nxt[i] = cond[i];
            cnt_nxt[i]  = '0;
            if (!filt_en) begin
                cond_nxt[i] = pin_in[i];
            end else if (pin_in[i] != cond[i]) begin
                if (cnt[i] == thresh) begin
                    cond_nxt[i] = pin_in[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [WIDTH-1:0] ev;
    logic [CW-1:0]    ev_chan;
    logic             ev_dir;
    logic             ev_multi;

    assign ev       = (cond_nxt & ~cond & rise_en) | (~cond_nxt & cond & fall_en);
    assign ev_multi = (ev & (ev - 1'b1)) != '0;

    // lowest-indexed event channel wins the single FIFO slot this cycle
    always_comb begin
        ev_chan = '0;
        ev_dir  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (ev[i]) begin
                ev_chan = CW'(i);
                ev_dir  = cond_nxt[i];
            end
        end
    end

    logic fifo_empty, fifo_full, push, pop, do_push, drop;
    logic [WIDTH-1:0] flag_clr;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = |ev;
    assign pop        = wr_fifo && !fifo_empty;
    assign do_push    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;
    assign flag_clr   = wr_flags ? cfg_wdata[WIDTH-1:0] : '0;

    // control registers, filter state, sticky flags, timestamp and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh  <= '0;
            filt_en <= 1'b0;
            rise_en <= '0;
            fall_en <= '0;
            flags   <= '0;
            ovf     <= 1'b0;
            cond    <= '0;
            ts      <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                thresh  <= cfg_wdata[FILT_W-1:0];
                filt_en <= cfg_wdata[8];
            end
            if (wr_edge) begin
                rise_en <= cfg_wdata[WIDTH-1:0];
                fall_en <= cfg_wdata[WIDTH+15:16];
            end
            // a new event beats a simultaneous clear
            flags <= (flags & ~flag_clr) | ev;
            ovf   <= (ovf & ~(wr_flags & cfg_wdata[31])) | drop;
            cond  <= cond_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            ts <= ts + 1'b1;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because valid comes from the pointers
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            fifo_ts[wr_ptr[AW-1:0]]    <= ts;
            fifo_chan[wr_ptr[AW-1:0]]  <= ev_chan;
            fifo_dir[wr_ptr[AW-1:0]]   <= ev_dir;
            fifo_multi[wr_ptr[AW-1:0]] <= ev_multi;
        end
    end

    logic [AW-1:0] rd_idx;
    assign rd_idx = rd_ptr[AW-1:0];

    // register read mux; forced to reset values while rst is held
    always_comb begin
        cfg_rdata = '0;
        if (!rst) begin
            case (cfg_addr)
                2'd0: begin
                    cfg_rdata[FILT_W-1:0] = thresh;
                    cfg_rdata[8]          = filt_en;
                end
                2'd1: begin
                    cfg_rdata[WIDTH-1:0]     = rise_en;
                    cfg_rdata[WIDTH+15:16]   = fall_en;
                end
                2'd2: begin
                    cfg_rdata[WIDTH-1:0] = flags;
                    cfg_rdata[31]        = ovf;
                end
                default: begin
                    if (!fifo_empty) begin
                        cfg_rdata[31]       = 1'b1;
                        cfg_rdata[30]       = ovf;
                        cfg_rdata[29]       = fifo_multi[rd_idx];
                        cfg_rdata[28]       = fifo_dir[rd_idx];
                        cfg_rdata[26:24]    = fifo_chan[rd_idx];
                        cfg_rdata[TS_W-1:0] = fifo_ts[rd_idx];
                    end
                end
            endcase
        end
    end

    assign cond_out = rst ? '0 : cond;
    assign irq      = !rst && ((|flags) || ovf || !fifo_empty);

endmodule

// File: doc/prism_in_cond.md
# prism_in_cond

Input-conditioning stage that sits directly upstream of the PRISM peripheral and produces the filtered input vector consumed as PRISM `in_data`. Each channel has a programmable glitch filter, rising/falling edge detection, sticky edge flags, and a timestamped event FIFO that the CPU reads over a small register port. Its inputs are pin levels that have already been synchronized by the TinyQV input PMOD logic.

## Interface
Parameters:
- `WIDTH`, 7: number of input channels, legal range 1..8.
- `FILT_W`, 4: filter counter / threshold width.
- `DEPTH`, 4: event FIFO entries, power of two.
- `TS_W`, 16: timestamp width, legal range up to 16.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `pin_in`  in  WIDTH  synchronized raw pin levels.
- `cfg_wr`  in  1  register write strobe, one cycle per write.
- `cfg_addr`  in  2  register select.
- `cfg_wdata`  in  32  write data.
- `cfg_rdata`  out  32  combinational read data for `cfg_addr`.
- `cond_out`  out  WIDTH  filtered levels, feeds PRISM `in_data`.
- `irq`  out  1  level interrupt.

## Operation
Registers:
- Addr 0 CTRL, R/W:
  - [FILT_W-1:0] `thresh`.
  - [8] `filt_en`.
- Addr 1 EDGE, R/W:
  - [WIDTH-1:0] `rise_en`.
  - [WIDTH+15:16] `fall_en`.
- Addr 2 FLAGS:
  - Read: [WIDTH-1:0] sticky edge flags; [31] overflow sticky.
  - Write: 1-to-clear, same bit positions.
- Addr 3 FIFO:
  - Read: head entry, non-popping.
  - Write: pops one entry; the data value is ignored.
- FIFO entry format, all other bits 0:
  - [31] valid; reads as 0 when empty, and then all other entry bits also read 0.
  - [30] overflow sticky.
  - [29] multi.
  - [28] dir, 1 = rising.
  - [26:24] channel.
  - [TS_W-1:0] timestamp.

Filter, per channel, evaluated each cycle:
- `filt_en=0`: `cond_out` <= `pin_in`; counter forced to 0.
- `filt_en=1`, `pin != cond` and `cnt == thresh`: `cond` <= `pin`; `cnt` <= 0.
- `filt_en=1`, `pin != cond` otherwise: `cnt` <= `cnt+1`.
- `filt_en=1`, `pin == cond`: `cnt` <= 0.
- Result: an input change must be held for `thresh+1` consecutive samples. `thresh=0` passes the input through with 1 cycle latency.
- Writing a new `thresh` does not clear the counters. If `cnt` is already greater than the new `thresh`, the counter keeps incrementing, wraps, and the flip occurs when it reaches `thresh`.

Edge detection and events:
- An event is a `cond_out` bit flip whose direction is enabled in `rise_en` / `fall_en`.
- Each event sets that channel's sticky flag.
- One FIFO push per cycle, for the lowest-indexed event channel. If more than one channel had an event that cycle, the pushed entry has `multi=1`; the other channels are recorded in flags only.
- `timestamp` = free-running TS_W counter value before the edge; the counter wraps modulo 2^TS_W.
- Push while full and no pop in the same cycle: the entry is dropped and overflow sticky is set.
- Push and pop in the same cycle while full: both happen, nothing is dropped.
- Pop while empty: ignored. Push and pop in the same cycle while empty: the push happens and the pop is ignored.
- Overflow sticky appears in FLAGS[31] and in the [30] bit of every FIFO read.
- FLAGS write-1-to-clear: if a set and a clear hit the same bit in the same cycle, the set wins.

Interrupt:
- `irq` = |flags | overflow | (FIFO non-empty).

## Timing
- Reset values: all registers, counters, flags, FIFO pointers and the timestamp counter are 0.
- Outputs while `rst` is high: `cond_out=0`, `irq=0`; `cfg_rdata` shows the reset values.
- Reset asserted mid-filter or with the FIFO partly full: state is cleared at the next edge and no event is generated by the clear.
- Flips of `cond_out` caused by reset deassertion are normal events, provided an enable is set.
- Writes take effect at the clock edge; the new value is readable in the next cycle.
- A flag or FIFO entry becomes visible on the same edge as the `cond_out` flip that caused it.
- `irq` is combinational from registered state, so it is high in the cycle after the event edge.
- With `filt_en=1` and a stable input change first sampled at edge k, `cond_out` updates at edge k+`thresh`.

## Test plan
- Filter pass, `thresh=3`, `filt_en=1`: `pin_in[2]` 0→1 held 4 cycles → `cond_out[2]` rises at the 4th edge. A 3-cycle pulse → no change and no event.
- Event capture, `rise_en=0x01`, `fall_en=0`, `thresh=0`:
  - `pin_in[0]` toggles 0→1→0 → exactly one FIFO entry: valid=1, dir=1, chan=0, timestamp = counter at the flip.
  - FLAGS reads 0x01 and `irq=1`.
  - Write 0x01 to FLAGS and pop → `irq=0`.
- Simultaneous events: channels 1 and 4 rise in the same cycle with both rise enables set → one entry with chan=1, multi=1; FLAGS=0x12.
- Overflow:
  - 5 enabled events with no pop, `DEPTH=4` → 4 entries, FLAGS[31]=1.
  - Pop and push in the same cycle when full → count stays 4, no new overflow.
- W1C race: a FLAGS clear of bit 3 in the same cycle as a channel 3 event → bit 3 remains set.
- Reset mid-operation: `rst` pulsed with 2 FIFO entries and `cnt=2` pending → FIFO empty, `cond_out=0`, timestamp restarts at 0, `irq=0`.
